barrel_shift_sequencer: RTL and testbench

//  Upstream driver for the 4-bit barrel shifter (fourbitbarrelshifter). Accepts one 4-bit word over a

---
 rtl/barrel_seq_pkg.sv | 23 ++
 rtl/fourbitbarrelshifter.sv | 19 +
 rtl/barrel_shift_sequencer.sv | 120 ++++++++++++
 tb/tb_barrel_shift_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/barrel_seq_pkg.sv
// Shared widths, state encoding and result-beat payload for barrel_shift_sequencer.
package barrel_seq_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
        logic              last;
    } beat_t;

    // Even-parity bit of a data word (1 when an odd number of bits are set).
    function automatic logic data_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/fourbitbarrelshifter.sv
// 4-bit rotate-left barrel shifter: dout = din rotated left by sel positions.
module fourbitbarrelshifter (
    input  logic [3:0] din,
    input  logic [1:0] sel,
    output logic [3:0] dout
);

    // Pure mux network selecting one of the four rotations.
    always_comb begin
        dout = din;
        case (sel)
            2'd0:    dout = din;
            2'd1:    dout = {din[2:0], din[3]};
            2'd2:    dout = {din[1:0], din[3:2]};
            default: dout = {din[0], din[3:1]};
        endcase
    end

endmodule

// File: rtl/barrel_shift_sequencer.sv
// Accepts one word over valid/ready, sweeps the barrel shifter sel from 0 to MAX_SEL
// and streams each registered result with backpressure.
// Optional build macro: BSEQ_PARITY_EN adds a registered out_parity output.
module barrel_shift_sequencer
    import barrel_seq_pkg::*;
#(
    parameter int unsigned MAX_SEL = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_last,
`ifdef BSEQ_PARITY_EN
    output logic              out_parity,
`endif
    output logic              busy
);

    localparam logic [0:0]       S_IDLE   = IDLE;
    localparam logic [0:0]       S_RUN    = RUN;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(MAX_SEL);

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    beat_t             beat_q, beat_d;
    logic              out_valid_d;
    logic              in_ready_d;
    logic              busy_d;
    logic [DATA_W-1:0] shift_out;
    logic              slot_free;
`ifdef BSEQ_PARITY_EN
    logic              parity_d;
`endif

    fourbitbarrelshifter u_shifter (
        .din  (data_q),
        .sel  (sel_q),
        .dout (shift_out)
    );

    assign slot_free = !out_valid || out_ready;
    assign out_data  = beat_q.data;
    assign out_sel   = beat_q.sel;
    assign out_last  = beat_q.last;

    // Next-state, sweep datapath and output-slot control.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        sel_d       = sel_q;
        beat_d      = beat_q;
        out_valid_d = out_valid && !out_ready;
`ifdef BSEQ_PARITY_EN
        parity_d    = out_parity;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    sel_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (slot_free) begin
                    beat_d.data = shift_out;
                    beat_d.sel  = sel_q;
                    beat_d.last = (sel_q == LAST_SEL);
                    out_valid_d = 1'b1;
`ifdef BSEQ_PARITY_EN
                    parity_d    = data_parity(shift_out);
`endif
                    if (sel_q == LAST_SEL) begin
                        state_d = S_IDLE;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d == S_RUN);
    end

    // State, sweep and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            sel_q      <= '0;
            beat_q     <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
`ifdef BSEQ_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            beat_q     <= beat_d;
            out_valid  <= out_valid_d;
            in_ready   <= in_ready_d;
            busy       <= busy_d;
`ifdef BSEQ_PARITY_EN
            out_parity <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Directed bench for barrel_shift_sequencer (MAX_SEL=3 and MAX_SEL=1 instances).
module tb_barrel_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [3:0] in_data, out_data;
    logic [1:0] out_sel;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
    logic [3:0] in_data1, out_data1;
    logic [1:0] out_sel1;
`ifdef BSEQ_PARITY_EN
    logic       out_parity, out_parity1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    barrel_shift_sequencer #(.MAX_SEL(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_last(out_last),
`ifdef BSEQ_PARITY_EN
        .out_parity(out_parity),
`endif
        .busy(busy)
    );

    barrel_shift_sequencer #(.MAX_SEL(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_sel(out_sel1), .out_last(out_last1),
`ifdef BSEQ_PARITY_EN
        .out_parity(out_parity1),
`endif
        .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one word with out_ready=1; exp holds beats sel0..sel3 from the top nibble down.
    task automatic run_word(input string tag, input logic [3:0] d, input logic [15:0] exp,
                            input logic par);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        step();
        check({tag, "_acc_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_acc_busy"}, 32'(busy), 32'd1);
        in_valid = 1'b0;
        in_data  = ~d;
        for (int k = 0; k < 4; k++) begin
            step();
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_data"}, 32'(out_data), 32'(exp[15-4*k -: 4]));
            check({tag, "_sel"}, 32'(out_sel), 32'(k));
            check({tag, "_last"}, 32'(out_last), 32'(k == 3));
            check({tag, "_busy"}, 32'(busy), 32'(k != 3));
            check({tag, "_in_ready"}, 32'(in_ready), 32'(k == 3));
`ifdef BSEQ_PARITY_EN
            check({tag, "_parity"}, 32'(out_parity), 32'(par));
`else
            if (par === 1'bx) $display("note: unknown parity argument for %s", tag);
`endif
        end
        step();
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    endtask

    logic [15:0] exp_a;
    logic [7:0]  exp_b;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = 4'h0; out_ready1 = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
`ifdef BSEQ_PARITY_EN
        check("rst_parity", 32'(out_parity), 32'd0);
`endif

        // 1: single bit walks left
        run_word("t1", 4'b0001, 16'h1248, 1'b1);
        // 2: alternating pattern
        run_word("t2", 4'b1010, 16'hA5A5, 1'b0);

        // 3: stall after the first beat
        in_valid = 1'b1; in_data = 4'b0001; out_ready = 1'b0;
        step();
        in_valid = 1'b0; in_data = 4'b1111;
        step();
        check("t3_first_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_data", 32'(out_data), 32'h1);
            check("t3_hold_sel", 32'(out_sel), 32'd0);
            check("t3_hold_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        exp_a = 16'h1248;
        for (int k = 1; k < 4; k++) begin
            step();
            check("t3_resume_data", 32'(out_data), 32'(exp_a[15-4*k -: 4]));
            check("t3_resume_sel", 32'(out_sel), 32'(k));
            check("t3_resume_last", 32'(out_last), 32'(k == 3));
        end
        step();
        check("t3_drain_valid", 32'(out_valid), 32'd0);

        // 4: reset while the sel=2 beat is presented
        in_valid = 1'b1; in_data = 4'b0001; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("t4_pre_sel", 32'(out_sel), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_rst_valid", 32'(out_valid), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_in_ready", 32'(in_ready), 32'd1);
        run_word("t4_restart", 4'b1010, 16'hA5A5, 1'b0);

        // 5: back-to-back words with in_valid held
        in_valid = 1'b1; in_data = 4'b0001; out_ready = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_w0_data", 32'(out_data), 32'(exp_a[15-4*k -: 4]));
            check("t5_w0_sel", 32'(out_sel), 32'(k));
        end
        check("t5_ready_after_last", 32'(in_ready), 32'd1);
        in_data = 4'b1010;
        step();
        check("t5_accept_in_ready", 32'(in_ready), 32'd0);
        check("t5_gap_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        exp_a = 16'hA5A5;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_w1_data", 32'(out_data), 32'(exp_a[15-4*k -: 4]));
            check("t5_w1_sel", 32'(out_sel), 32'(k));
            check("t5_w1_last", 32'(out_last), 32'(k == 3));
        end
        step();
        check("t5_drain_valid", 32'(out_valid), 32'd0);

        // 5b: MAX_SEL=1 instance, two beats per word, back-to-back
        in_valid1 = 1'b1; in_data1 = 4'b0001;
        step();
        exp_b = 8'h12;
        for (int k = 0; k < 2; k++) begin
            step();
            check("t5b_w0_valid", 32'(out_valid1), 32'd1);
            check("t5b_w0_data", 32'(out_data1), 32'(exp_b[7-4*k -: 4]));
            check("t5b_w0_sel", 32'(out_sel1), 32'(k));
            check("t5b_w0_last", 32'(out_last1), 32'(k == 1));
        end
        check("t5b_ready_after_last", 32'(in_ready1), 32'd1);
        in_data1 = 4'b1010;
        step();
        in_valid1 = 1'b0;
        exp_b = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            step();
            check("t5b_w1_data", 32'(out_data1), 32'(exp_b[7-4*k -: 4]));
            check("t5b_w1_sel", 32'(out_sel1), 32'(k));
            check("t5b_w1_last", 32'(out_last1), 32'(k == 1));
        end
        step();
        check("t5b_drain_valid", 32'(out_valid1), 32'd0);
        check("t5b_idle_busy", 32'(busy1), 32'd0);

        // 6: parity-relevant words (parity checked only in the parity build)
        run_word("t6_0111", 4'b0111, 16'h7EDB, 1'b1);
        run_word("t6_0000", 4'b0000, 16'h0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
